// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: opcodes, select
// encodings, control bundle and FSM state encoding.
package bip_pkg;

  localparam int OPC_BITS = 5;

  localparam logic [OPC_BITS-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPC_BITS-1:0] OP_STO  = 5'b00001;
  localparam logic [OPC_BITS-1:0] OP_LD   = 5'b00010;
  localparam logic [OPC_BITS-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPC_BITS-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPC_BITS-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPC_BITS-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPC_BITS-1:0] OP_SUBI = 5'b00111;
  localparam logic [OPC_BITS-1:0] OP_BEQ  = 5'b01000;
  localparam logic [OPC_BITS-1:0] OP_BNE  = 5'b01001;
  localparam logic [OPC_BITS-1:0] OP_JMP  = 5'b01010;

  localparam logic [1:0] SEL_A_MEM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  localparam logic SEL_B_MEM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_ALWAYS = 2'd1,
    BR_ZERO   = 2'd2,
    BR_NZERO  = 2'd3
  } br_e;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       write_acc;
    logic       operation;
    logic       write_mem;
    logic       read_mem;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic br_taken(
    input br_e  kind,
    input logic acc_zero
  );
    logic t;
    t = 1'b0;
    unique case (kind)
      BR_ALWAYS: t = 1'b1;
      BR_ZERO:   t = acc_zero;
      BR_NZERO:  t = ~acc_zero;
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/bip_decoder_ext.sv
// Combinational opcode decoder: datapath controls, branch kind,
// halt and illegal-opcode flags.
module bip_decoder_ext
  import bip_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] i_opcode,
  output ctrl_t            o_ctrl,
  output logic             o_is_branch,
  output br_e              o_br_kind,
  output logic             o_is_halt,
  output logic             o_illegal
);

  localparam logic [OPC_W-1:0] K_HLT  = OPC_W'(OP_HLT);
  localparam logic [OPC_W-1:0] K_STO  = OPC_W'(OP_STO);
  localparam logic [OPC_W-1:0] K_LD   = OPC_W'(OP_LD);
  localparam logic [OPC_W-1:0] K_LDI  = OPC_W'(OP_LDI);
  localparam logic [OPC_W-1:0] K_ADD  = OPC_W'(OP_ADD);
  localparam logic [OPC_W-1:0] K_ADDI = OPC_W'(OP_ADDI);
  localparam logic [OPC_W-1:0] K_SUB  = OPC_W'(OP_SUB);
  localparam logic [OPC_W-1:0] K_SUBI = OPC_W'(OP_SUBI);
  localparam logic [OPC_W-1:0] K_BEQ  = OPC_W'(OP_BEQ);
  localparam logic [OPC_W-1:0] K_BNE  = OPC_W'(OP_BNE);
  localparam logic [OPC_W-1:0] K_JMP  = OPC_W'(OP_JMP);

  always_comb begin
    o_ctrl      = CTRL_NONE;
    o_is_branch = 1'b0;
    o_br_kind   = BR_NONE;
    o_is_halt   = 1'b0;
    o_illegal   = 1'b0;
    unique case (1'b1)
      (i_opcode == K_HLT): o_is_halt = 1'b1;
      (i_opcode == K_STO): o_ctrl.write_mem = 1'b1;
      (i_opcode == K_LD): begin
        o_ctrl.read_mem  = 1'b1;
        o_ctrl.sel_a     = SEL_A_MEM;
        o_ctrl.write_acc = 1'b1;
      end
      (i_opcode == K_LDI): begin
        o_ctrl.sel_a     = SEL_A_IMM;
        o_ctrl.write_acc = 1'b1;
      end
      (i_opcode == K_ADD),
      (i_opcode == K_SUB): begin
        o_ctrl.read_mem  = 1'b1;
        o_ctrl.sel_a     = SEL_A_ALU;
        o_ctrl.sel_b     = SEL_B_MEM;
        o_ctrl.write_acc = 1'b1;
        o_ctrl.operation =
          (i_opcode == K_SUB) ? ALU_SUB : ALU_ADD;
      end
      (i_opcode == K_ADDI),
      (i_opcode == K_SUBI): begin
        o_ctrl.sel_a     = SEL_A_ALU;
        o_ctrl.sel_b     = SEL_B_IMM;
        o_ctrl.write_acc = 1'b1;
        o_ctrl.operation =
          (i_opcode == K_SUBI) ? ALU_SUB : ALU_ADD;
      end
      (i_opcode == K_BEQ): begin
        o_is_branch = 1'b1;
        o_br_kind   = BR_ZERO;
      end
      (i_opcode == K_BNE): begin
        o_is_branch = 1'b1;
        o_br_kind   = BR_NZERO;
      end
      (i_opcode == K_JMP): begin
        o_is_branch = 1'b1;
        o_br_kind   = BR_ALWAYS;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bip_control_ext.sv
// BIP control unit: run/wait/halt FSM and program counter,
// driving datapath controls from the decoded instruction.
module bip_control_ext
  import bip_pkg::*;
#(
  parameter  int PC_W    = 11,
  parameter  int OPC_W   = 5,
  parameter  int OPR_W   = 11,
  localparam int INSTR_W = OPC_W + OPR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [INSTR_W-1:0] i_instruction,
  input  logic               i_instr_valid,
  input  logic               i_acc_zero,
  output logic [PC_W-1:0]    o_prog_address,
  output logic [OPR_W-1:0]   o_operand,
  output logic [1:0]         o_sel_a,
  output logic               o_sel_b,
  output logic               o_write_acc,
  output logic               o_operation,
  output logic               o_write_mem,
  output logic               o_read_mem,
  output logic               o_done,
  output logic               o_illegal,
  output logic               o_busy
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;

  logic [OPC_W-1:0]  opcode;
  logic [OPR_W-1:0]  operand;
  logic [PC_W-1:0]   offset;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   pc_tgt;

  ctrl_t             dec_ctrl;
  ctrl_t             ctrl;
  logic              dec_is_branch;
  br_e               dec_br_kind;
  logic              dec_is_halt;
  logic              dec_illegal;
  logic              exec;
  logic              taken;

  assign opcode  = i_instruction[INSTR_W-1 -: OPC_W];
  assign operand = i_instruction[OPR_W-1:0];

  bip_decoder_ext #(
    .OPC_W (OPC_W)
  ) u_dec (
    .i_opcode    (opcode),
    .o_ctrl      (dec_ctrl),
    .o_is_branch (dec_is_branch),
    .o_br_kind   (dec_br_kind),
    .o_is_halt   (dec_is_halt),
    .o_illegal   (dec_illegal)
  );

  // Branch offset fitted to the PC: truncate or sign-extend.
  if (PC_W <= OPR_W) begin : g_trunc
    assign offset = operand[PC_W-1:0];
  end else begin : g_sext
    assign offset = {{(PC_W-OPR_W){operand[OPR_W-1]}}, operand};
  end

  assign pc_inc = pc_q + PC_W'(1);
  assign pc_tgt = pc_q + offset;
  assign exec   = (state_q == ST_RUN) && i_instr_valid;
  assign taken  = dec_is_branch
               && br_taken(dec_br_kind, i_acc_zero);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!i_instr_valid) begin
          state_d = ST_WAIT;
        end else if (dec_is_halt) begin
          state_d = ST_HALT;
        end else begin
          pc_d = taken ? pc_tgt : pc_inc;
        end
      end
      ST_WAIT: begin
        if (i_instr_valid) state_d = ST_RUN;
      end
      ST_HALT: begin
        if (i_start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign ctrl = exec ? dec_ctrl : CTRL_NONE;

  assign o_prog_address = pc_q;
  assign o_operand      = operand;
  assign o_sel_a        = ctrl.sel_a;
  assign o_sel_b        = ctrl.sel_b;
  assign o_write_acc    = ctrl.write_acc;
  assign o_operation    = ctrl.operation;
  assign o_write_mem    = ctrl.write_mem;
  assign o_read_mem     = ctrl.read_mem;
  assign o_done         = (state_q == ST_HALT);
  assign o_busy         = (state_q == ST_RUN)
                       || (state_q == ST_WAIT);
  assign o_illegal      = exec && dec_illegal;

endmodule

// File: tb/tb_bip_control_ext.sv
// Bench for bip_control_ext: vector table through a scoreboard,
// plus a short 8-bit PC build sequence.
module tb_bip_control_ext;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, valid, az;
  logic [15:0] instr;
  logic [10:0] addr;
  logic [10:0] opnd;
  logic [1:0]  sel_a;
  logic        sel_b, wacc, oper, wmem, rmem;
  logic        done, ill, busy;

  logic        s8_start, s8_valid, s8_az;
  logic [15:0] s8_instr;
  logic [7:0]  s8_addr;
  logic [10:0] s8_opnd;
  logic [1:0]  s8_sel_a;
  logic        s8_sel_b, s8_wacc, s8_oper, s8_wmem, s8_rmem;
  logic        s8_done, s8_ill, s8_busy;

  always #5 clk = ~clk;

  bip_control_ext u_dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (start),
    .i_instruction  (instr),
    .i_instr_valid  (valid),
    .i_acc_zero     (az),
    .o_prog_address (addr),
    .o_operand      (opnd),
    .o_sel_a        (sel_a),
    .o_sel_b        (sel_b),
    .o_write_acc    (wacc),
    .o_operation    (oper),
    .o_write_mem    (wmem),
    .o_read_mem     (rmem),
    .o_done         (done),
    .o_illegal      (ill),
    .o_busy         (busy)
  );

  bip_control_ext #(.PC_W(8)) u_dut8 (
    .clk            (clk),
    .rst            (rst),
    .i_start        (s8_start),
    .i_instruction  (s8_instr),
    .i_instr_valid  (s8_valid),
    .i_acc_zero     (s8_az),
    .o_prog_address (s8_addr),
    .o_operand      (s8_opnd),
    .o_sel_a        (s8_sel_a),
    .o_sel_b        (s8_sel_b),
    .o_write_acc    (s8_wacc),
    .o_operation    (s8_oper),
    .o_write_mem    (s8_wmem),
    .o_read_mem     (s8_rmem),
    .o_done         (s8_done),
    .o_illegal      (s8_ill),
    .o_busy         (s8_busy)
  );

  localparam logic [4:0] O_HLT  = 5'd0;
  localparam logic [4:0] O_STO  = 5'd1;
  localparam logic [4:0] O_LD   = 5'd2;
  localparam logic [4:0] O_LDI  = 5'd3;
  localparam logic [4:0] O_ADD  = 5'd4;
  localparam logic [4:0] O_ADDI = 5'd5;
  localparam logic [4:0] O_SUB  = 5'd6;
  localparam logic [4:0] O_SUBI = 5'd7;
  localparam logic [4:0] O_BEQ  = 5'd8;
  localparam logic [4:0] O_BNE  = 5'd9;
  localparam logic [4:0] O_JMP  = 5'd10;

  // {sel_a[1:0], sel_b, write_acc, operation, write_mem, read_mem}
  localparam logic [6:0] K_NONE = 7'b00_0_0_0_0_0;
  localparam logic [6:0] K_STO  = 7'b00_0_0_0_1_0;
  localparam logic [6:0] K_LD   = 7'b00_0_1_0_0_1;
  localparam logic [6:0] K_LDI  = 7'b01_0_1_0_0_0;
  localparam logic [6:0] K_ADD  = 7'b10_0_1_0_0_1;
  localparam logic [6:0] K_ADDI = 7'b10_1_1_0_0_0;
  localparam logic [6:0] K_SUB  = 7'b10_0_1_1_0_1;
  localparam logic [6:0] K_SUBI = 7'b10_1_1_1_0_0;

  typedef struct packed {
    logic        rst;
    logic        start;
    logic        valid;
    logic        az;
    logic [15:0] instr;
    logic [10:0] addr;
    logic [6:0]  ctl;
    logic        ill;
    logic        done;
    logic        busy;
  } vec_t;

  typedef struct packed {
    int          idx;
    logic [10:0] addr;
    logic [6:0]  ctl;
    logic        ill;
    logic        done;
    logic        busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic logic [15:0] ins(
    input logic [4:0]  o,
    input logic [10:0] r
  );
    return {o, r};
  endfunction

  function automatic vec_t mk(
    input logic r, s, v, z,
    input logic [15:0] i,
    input logic [10:0] a,
    input logic [6:0]  c,
    input logic il, dn, bs
  );
    vec_t t;
    t.rst = r; t.start = s; t.valid = v; t.az = z;
    t.instr = i; t.addr = a; t.ctl = c;
    t.ill = il; t.done = dn; t.busy = bs;
    return t;
  endfunction

  task automatic chk(
    input string       nm,
    input int          idx,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d] got %0h expected %0h",
                  nm, idx, act, exp);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("addr", e.idx, 32'(addr), 32'(e.addr));
      chk("ctl", e.idx,
          32'({sel_a, sel_b, wacc, oper, wmem, rmem}),
          32'(e.ctl));
      chk("illegal", e.idx, 32'(ill), 32'(e.ill));
      chk("done", e.idx, 32'(done), 32'(e.done));
      chk("busy", e.idx, 32'(busy), 32'(e.busy));
    end
  end

  task automatic cyc8(
    input string       nm,
    input logic        s, v, z,
    input logic [15:0] i,
    input logic [7:0]  ea,
    input logic        ew, ed
  );
    @(posedge clk);
    #1;
    s8_start = s; s8_valid = v; s8_az = z; s8_instr = i;
    @(negedge clk);
    chk({nm, "_addr"}, 8, 32'(s8_addr), 32'(ea));
    chk({nm, "_wacc"}, 8, 32'(s8_wacc), 32'(ew));
    chk({nm, "_done"}, 8, 32'(s8_done), 32'(ed));
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; start = 1'b0; valid = 1'b0; az = 1'b0;
    instr = '0;
    s8_start = 1'b0; s8_valid = 1'b0; s8_az = 1'b0;
    s8_instr = '0;

    // rst start valid az instr addr ctl ill done busy
    vecs.push_back(mk(1,0,1,0,ins(O_LDI,5),  0,K_NONE,0,0,0));
    vecs.push_back(mk(1,1,0,0,ins(O_HLT,0),  0,K_NONE,0,0,0));
    vecs.push_back(mk(1,0,1,0,ins(O_LDI,5),  0,K_LDI ,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_ADDI,3), 1,K_ADDI,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_STO,7),  2,K_STO ,0,0,1));
    vecs.push_back(mk(1,0,0,0,ins(O_LDI,1),  3,K_NONE,0,0,1));
    vecs.push_back(mk(1,0,0,0,ins(O_LDI,1),  3,K_NONE,0,0,1));
    vecs.push_back(mk(1,0,0,0,ins(O_LDI,1),  3,K_NONE,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_HLT,0),  3,K_NONE,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_HLT,0),  3,K_NONE,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_LDI,1),  3,K_NONE,0,1,0));
    vecs.push_back(mk(1,1,0,0,ins(O_LDI,1),  3,K_NONE,0,1,0));
    vecs.push_back(mk(1,0,1,0,ins(O_JMP,4),  0,K_NONE,0,0,1));
    vecs.push_back(mk(1,0,1,1,ins(O_BEQ,11'h7FE),4,K_NONE,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_JMP,2),  2,K_NONE,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_BEQ,11'h7FE),4,K_NONE,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_JMP,1),  5,K_NONE,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(5'h1F,0),  6,K_NONE,1,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_LD,9),   7,K_LD  ,0,0,1));
    vecs.push_back(mk(1,0,1,1,ins(O_BNE,3),  8,K_NONE,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_BNE,11'h7FD),9,K_NONE,0,0,1));
    vecs.push_back(mk(1,1,1,0,ins(O_SUB,1),  6,K_SUB ,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_SUBI,2), 7,K_SUBI,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_JMP,11'h7F8),8,K_NONE,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_JMP,11'h7FF),0,K_NONE,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_ADD,4),  2047,K_ADD,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_JMP,11'h7FF),0,K_NONE,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_JMP,1),  2047,K_NONE,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_STO,1),  0,K_STO ,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(5'h0B,0),  1,K_NONE,1,0,1));
    vecs.push_back(mk(0,0,1,0,ins(O_JMP,5),  2,K_NONE,0,0,1));
    vecs.push_back(mk(1,0,1,0,ins(O_LDI,1),  0,K_NONE,0,0,0));

    repeat (2) @(posedge clk);

    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clk);
      #1;
      rst   = vecs[k].rst;
      start = vecs[k].start;
      valid = vecs[k].valid;
      az    = vecs[k].az;
      instr = vecs[k].instr;
      e.idx  = k;
      e.addr = vecs[k].addr;
      e.ctl  = vecs[k].ctl;
      e.ill  = vecs[k].ill;
      e.done = vecs[k].done;
      e.busy = vecs[k].busy;
      sb.push_back(e);
    end

    repeat (2) @(posedge clk);
    chk("sb_drain", 0, 32'(sb.size()), 32'd0);
    start = 1'b0; valid = 1'b0;

    cyc8("w_start", 1, 0, 0, ins(O_HLT,0),        0,   0, 0);
    cyc8("w_jmpm1", 0, 1, 0, ins(O_JMP,11'h7FF),  0,   0, 0);
    cyc8("w_add",   0, 1, 0, ins(O_ADD,1),        255, 1, 0);
    cyc8("w_jmp4",  0, 1, 0, ins(O_JMP,4),        0,   0, 0);
    cyc8("w_beq",   0, 1, 1, ins(O_BEQ,11'h7FE),  4,   0, 0);
    cyc8("w_hlt",   0, 1, 0, ins(O_HLT,0),        2,   0, 0);
    cyc8("w_halt",  0, 1, 0, ins(O_LDI,1),        2,   0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bip_control_ext.md
BIP_CONTROL_EXT -- requirements
Module: bip_control_ext

Interface
REQ-001 Parameter PC_W, default 11, program counter and program address width.
REQ-002 Parameter OPC_W, default 5, opcode field width.
REQ-003 Parameter OPR_W, default 11, operand field width; instruction width INSTR_W = OPC_W + OPR_W.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 i_start  input  1  run request; level-sampled in IDLE and HALT.
REQ-007 i_instruction  input  INSTR_W  program word at o_prog_address; opcode = MSB OPC_W bits, operand = low OPR_W bits.
REQ-008 i_instr_valid  input  1  i_instruction valid this cycle.
REQ-009 i_acc_zero  input  1  accumulator equals zero (datapath flag).
REQ-010 o_prog_address  output  PC_W  registered program counter.
REQ-011 o_operand  output  OPR_W  operand field, combinational passthrough.
REQ-012 o_sel_a  output  2  accumulator source select: 0 memory, 1 immediate, 2 ALU.
REQ-013 o_sel_b  output  1  ALU B select: 0 memory, 1 immediate.
REQ-014 o_write_acc / o_operation / o_write_mem / o_read_mem  output  1 each  accumulator write, ALU op (0 add, 1 sub), data memory write, data memory read.
REQ-015 o_done  output  1  high in HALT.
REQ-016 o_illegal  output  1  one-cycle pulse on undefined opcode.
REQ-017 o_busy  output  1  high in RUN or WAIT.

Function
REQ-018 FSM states IDLE, RUN, WAIT, HALT; IDLE->RUN when i_start=1; RUN->WAIT when i_instr_valid=0; WAIT->RUN when i_instr_valid=1; RUN->HALT on executed HLT; HALT->RUN with PC=0 when i_start=1.
REQ-019 An instruction executes only in a RUN cycle with i_instr_valid=1; single-cycle execution, controls combinational in that cycle, PC updates at that clock edge.
REQ-020 Opcodes: HLT 00000, STO 00001, LD 00010, LDI 00011, ADD 00100, ADDI 00101, SUB 00110, SUBI 00111, BEQ 01000, BNE 01001, JMP 01010; all others illegal.
REQ-021 Controls: STO write_mem; LD read_mem, sel_a=0, write_acc; LDI sel_a=1, write_acc; ADD/SUB read_mem, sel_a=2, sel_b=0, write_acc; ADDI/SUBI sel_a=2, sel_b=1, write_acc; SUB/SUBI operation=1; all others zero.
REQ-022 Next PC: PC+1 for non-branch; JMP, BEQ with i_acc_zero=1, BNE with i_acc_zero=0 -> PC + sign-extended operand; not-taken branch -> PC+1.
REQ-023 Operand sign-extended or truncated to PC_W before addition; all PC arithmetic modulo 2^PC_W (2^PC_W-1 + 1 -> 0).
REQ-024 HLT: PC holds, no controls asserted, o_done=1 from next cycle.
REQ-025 Illegal opcode: no controls, PC+1, o_illegal=1 that cycle only.
REQ-026 In IDLE, WAIT, HALT and RUN with i_instr_valid=0: all memory/acc controls 0, PC holds.
REQ-027 i_start while in RUN/WAIT is ignored.

Reset
REQ-028 rst=0 at a clock edge: state IDLE, PC=0, o_done=0, o_busy=0, o_illegal=0, all controls 0; overrides any in-flight instruction, including a taken branch in the same cycle.
REQ-029 Reset has priority over i_start and i_instr_valid.

Structure
REQ-030 Opcode constants, select encodings, FSM state encoding in shared package bip_pkg.
REQ-031 Decode in sub-module bip_decoder_ext (opcode in; controls, is_branch, is_halt, illegal out), purely combinational; FSM and PC in the top.

Verification
REQ-032 Reset, i_start=1, program LDI 5; ADDI 3; STO 7; HLT -> addresses 0,1,2,3, controls per REQ-021, o_done=1 from cycle after HLT, PC holds 3.
REQ-033 PC=4, BEQ operand -2 (0x7FE), i_acc_zero=1 -> next PC 2; same with i_acc_zero=0 -> next PC 5.
REQ-034 PC=2047 (PC_W=11), ADD -> next PC 0; JMP operand +1 at PC 2047 -> next PC 0.
REQ-035 i_instr_valid low 3 cycles mid-program -> state WAIT, PC frozen, all controls 0, resume at same address.
REQ-036 Opcode 11111 at PC 6 -> o_illegal pulse one cycle, no controls, PC 7.
REQ-037 rst=0 during taken JMP -> PC 0, state IDLE, controls 0; PC_W=8, OPR_W=11 build passes REQ-032..034 with modulo-256 arithmetic.
